// File: rtl/uart_pkg.sv
// uart_pkg: receiver/transmitter shared state encodings and default frame geometry.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

package uart_pkg;

  localparam int OVERSAMPLE_DEF = 8;
  localparam int DATA_BITS_DEF  = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input, reset value selectable.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// uart_rx: 8N1 oversampling UART receiver; mid-bit sampling, done / framing-error pulses.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_done,
  output logic                 o_rx_busy,
  output logic                 o_frame_err
);

  localparam int BW = $clog2(OVERSAMPLE);
  localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BW-1:0] B_HALF = BW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] B_LAST = BW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] C_LAST = CW'(DATA_BITS - 1);

  uart_state_t          state, state_nxt;
  logic [BW-1:0]        b_cnt, b_cnt_nxt;
  logic [CW-1:0]        bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] sh, sh_nxt;
  logic [DATA_BITS-1:0] data_nxt;
  logic                 rx_s, rx_s_d, fall;
  logic                 stop_hit, done_nxt, err_nxt, busy_nxt;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_s_d <= 1'b1;
    else     rx_s_d <= rx_s;
  end

  assign fall = rx_s_d & ~rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      b_cnt       <= '0;
      bit_cnt     <= '0;
      sh          <= '0;
      o_rx_data   <= '0;
      o_rx_done   <= 1'b0;
      o_rx_busy   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      b_cnt       <= b_cnt_nxt;
      bit_cnt     <= bit_cnt_nxt;
      sh          <= sh_nxt;
      o_rx_data   <= data_nxt;
      o_rx_done   <= done_nxt;
      o_rx_busy   <= busy_nxt;
      o_frame_err <= err_nxt;
    end
  end

  // The start-edge is taken on any clk; a coincident baud_tick is deliberately ignored.
  always_comb begin
    state_nxt   = state;
    b_cnt_nxt   = b_cnt;
    bit_cnt_nxt = bit_cnt;
    sh_nxt      = sh;
    stop_hit    = 1'b0;
    unique case (state)
      S_IDLE: begin
        b_cnt_nxt   = '0;
        bit_cnt_nxt = '0;
        if (fall) state_nxt = S_START;
      end
      S_START: begin
        if (baud_tick) begin
          if (b_cnt == B_HALF) begin
            b_cnt_nxt = '0;
            state_nxt = rx_s ? S_IDLE : S_DATA;
          end else begin
            b_cnt_nxt = b_cnt + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (b_cnt == B_LAST) begin
            b_cnt_nxt = '0;
            sh_nxt    = {rx_s, sh[DATA_BITS-1:1]};
            if (bit_cnt == C_LAST) begin
              bit_cnt_nxt = '0;
              state_nxt   = S_STOP;
            end else begin
              bit_cnt_nxt = bit_cnt + 1'b1;
            end
          end else begin
            b_cnt_nxt = b_cnt + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          if (b_cnt == B_LAST) begin
            b_cnt_nxt = '0;
            state_nxt = S_IDLE;
            stop_hit  = 1'b1;
          end else begin
            b_cnt_nxt = b_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    done_nxt = stop_hit & rx_s;
    err_nxt  = stop_hit & ~rx_s;
    busy_nxt = (state_nxt != S_IDLE);
    data_nxt = done_nxt ? sh : o_rx_data;
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frame stimulus checked against an event-level receiver model.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx;

  localparam int OS  = 8;
  localparam int DIV = 4;
  // start edge to visible pulse: half a bit to mid-start, nine full bits to mid-stop
  localparam longint LAT = 304;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    longint     due;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;
  logic       rx;
  logic [7:0] o_rx_data;
  logic       o_rx_done;
  logic       o_rx_busy;
  logic       o_frame_err;

  int         total = 0;
  int         bad = 0;
  longint     cyc = 0;
  int         tcnt = 0;
  logic [7:0] exp_last = 8'h00;
  ev_t        q[$];

  uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .baud_tick   (baud_tick),
    .rx          (rx),
    .o_rx_data   (o_rx_data),
    .o_rx_done   (o_rx_done),
    .o_rx_busy   (o_rx_busy),
    .o_frame_err (o_frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  initial begin
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      tcnt = (tcnt + 1) % DIV;
      baud_tick = (tcnt == 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: pulses must match the expected event queue in kind, data and cycle.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (q.size() > 0 && cyc > q[0].due) begin
        chk("event_missing_at_due", 32'(cyc), 32'(q[0].due));
        void'(q.pop_front());
      end
      chk("done_err_exclusive", {31'd0, o_rx_done & o_frame_err}, 32'd0);
      if (o_rx_done === 1'b1 || o_frame_err === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse", {30'd0, o_rx_done, o_frame_err}, 32'd0);
        end else begin
          chk("pulse_kind_err", {31'd0, o_frame_err}, {31'd0, q[0].is_err});
          chk("pulse_time", 32'(cyc), 32'(q[0].due));
          if (!q[0].is_err) begin
            chk("done_data", {24'd0, o_rx_data}, {24'd0, q[0].data});
            exp_last = q[0].data;
          end
          void'(q.pop_front());
        end
      end
      chk("rx_data_hold", {24'd0, o_rx_data}, {24'd0, exp_last});
    end
  end

  task automatic wait_tick();
    do @(posedge clk); while (baud_tick !== 1'b1);
    @(negedge clk);
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) wait_tick();
  endtask

  task automatic expect_ev(input bit is_err, input logic [7:0] d);
    ev_t e;
    e.is_err = is_err;
    e.data   = d;
    e.due    = cyc + LAT;
    q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int gap_bits);
    rx = 1'b0;
    expect_ev(!stop, d);
    wait_ticks(OS);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      if (i == 4) begin
        wait_ticks(OS / 2);
        chk("busy_mid_frame", {31'd0, o_rx_busy}, 32'd1);
        wait_ticks(OS / 2);
      end else begin
        wait_ticks(OS);
      end
    end
    rx = stop;
    wait_ticks(OS);
    chk("busy_after_stop", {31'd0, o_rx_busy}, 32'd0);
    rx = 1'b1;
    wait_ticks(OS * gap_bits);
  endtask

  initial begin
    logic [7:0] d;
    logic       s;
    int         g;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_data", {24'd0, o_rx_data}, 32'd0);
    chk("reset_done", {31'd0, o_rx_done}, 32'd0);
    chk("reset_busy", {31'd0, o_rx_busy}, 32'd0);
    chk("reset_err", {31'd0, o_frame_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_ticks(2 * OS);

    // glitch: two ticks low then high again
    rx = 1'b0;
    wait_ticks(2);
    rx = 1'b1;
    wait_ticks(2 * OS);
    chk("glitch_data", {24'd0, o_rx_data}, 32'h00);
    chk("glitch_busy", {31'd0, o_rx_busy}, 32'd0);

    send_frame(8'h55, 1'b1, 1);
    chk("lit_55", {24'd0, o_rx_data}, 32'h55);

    send_frame(8'hA3, 1'b1, 0);
    send_frame(8'h0F, 1'b1, 1);
    chk("lit_0f", {24'd0, o_rx_data}, 32'h0F);

    send_frame(8'h3C, 1'b0, 1);
    chk("lit_ferr_hold", {24'd0, o_rx_data}, 32'h0F);
    send_frame(8'h81, 1'b1, 1);
    chk("lit_81", {24'd0, o_rx_data}, 32'h81);

    // reset during bit 4 of 0xFF
    rx = 1'b0;
    wait_ticks(OS);
    rx = 1'b1;
    wait_ticks(4 * OS + OS / 2);
    rst = 1'b1;
    #1;
    chk("midrst_data", {24'd0, o_rx_data}, 32'd0);
    chk("midrst_busy", {31'd0, o_rx_busy}, 32'd0);
    chk("midrst_done", {31'd0, o_rx_done}, 32'd0);
    chk("midrst_err", {31'd0, o_frame_err}, 32'd0);
    exp_last = 8'h00;
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_ticks(2 * OS);
    send_frame(8'h12, 1'b1, 1);
    chk("lit_12", {24'd0, o_rx_data}, 32'h12);

    // break: line low for 30 bit periods, exactly one framing error
    rx = 1'b0;
    expect_ev(1'b1, 8'h00);
    wait_ticks(30 * OS);
    rx = 1'b1;
    wait_ticks(2 * OS);
    send_frame(8'h7E, 1'b1, 1);
    chk("lit_7e", {24'd0, o_rx_data}, 32'h7E);

    for (int n = 0; n < 24; n++) begin
      d = 8'($urandom_range(0, 255));
      s = ($urandom_range(0, 3) != 0);
      g = s ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      send_frame(d, s, g);
    end

    wait_ticks(2 * OS);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
